// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, keeps one imem request in flight, buffers {pc, instr} for decode.
// Latency: a response in cycle N is visible at the buffer head in cycle N+1.
// Backpressure: requests stop while the buffer is full; fetch_pc holds until decode pops.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_req_ready_i,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic [31:0] fetch_pc_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [63:0]   head;
    logic          req_vld;
    logic          hs;
    logic          push;
    logic          pop;

    always_comb begin
        state_nxt = state;
        req_vld   = 1'b0;
        push      = 1'b0;
        case (state)
            S_REQ: begin
                req_vld = (count < DEPTH_C) && !rst;
                if (req_vld && imem_req_ready_i)
                    state_nxt = redirect_valid_i ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid_i) begin
                    // A redirect in the same cycle turns the response into a discard.
                    push      = !redirect_valid_i;
                    state_nxt = S_REQ;
                end else if (redirect_valid_i) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid_i)
                    state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase
    end

    assign hs            = req_vld && imem_req_ready_i;
    assign instr_valid_o = (count != '0);
    assign pop           = instr_valid_o && instr_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_REQ;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (redirect_valid_i) begin
                fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (hs) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {req_pc, imem_rsp_data_i};
    end

    // Head is masked so an empty buffer presents zeros rather than stale entries.
    assign head             = mem[rd_ptr];
    assign instr_o          = instr_valid_o ? head[31:0]  : 32'd0;
    assign instr_pc_o       = instr_valid_o ? head[63:32] : 32'd0;
    assign imem_req_valid_o = req_vld;
    assign imem_req_addr_o  = fetch_pc;
    assign fetch_pc_o       = fetch_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed cycle vectors for instr_fetch: free-run, reset, backpressure, redirects, wrap.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic [31:0] imem_req_addr_o;
    logic        imem_req_ready_i;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic [31:0] fetch_pc_o;

    int errors = 0;
    int checks = 0;

    instr_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .instr_ready_i    (instr_ready_i),
        .fetch_pc_o       (fetch_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rrdy;
        logic        rsp;
        logic [31:0] rdat;
        logic        irdy;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_ins;
        logic [31:0] e_fpc;
    } vec_t;

    function automatic vec_t v(input logic r, input logic rd, input logic [31:0] rpc,
                               input logic rrdy, input logic rsp, input logic [31:0] rdat,
                               input logic irdy, input logic erv, input logic [31:0] era,
                               input logic eiv, input logic [31:0] eipc, input logic [31:0] eins,
                               input logic [31:0] efpc);
        vec_t t;
        t.rst = r;     t.redir = rd;   t.rpc = rpc;   t.rrdy = rrdy;
        t.rsp = rsp;   t.rdat = rdat;  t.irdy = irdy; t.e_rv = erv;
        t.e_ra = era;  t.e_iv = eiv;   t.e_ipc = eipc; t.e_ins = eins;
        t.e_fpc = efpc;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        rst              = t.rst;
        redirect_valid_i = t.redir;
        redirect_pc_i    = t.rpc;
        imem_req_ready_i = t.rrdy;
        imem_rsp_valid_i = t.rsp;
        imem_rsp_data_i  = t.rdat;
        instr_ready_i    = t.irdy;
        @(negedge clk);
        chk("req_valid", idx, {31'd0, imem_req_valid_o}, {31'd0, t.e_rv});
        if (t.e_rv)
            chk("req_addr", idx, imem_req_addr_o, t.e_ra);
        chk("instr_valid", idx, {31'd0, instr_valid_o}, {31'd0, t.e_iv});
        if (t.e_iv || t.rst) begin
            chk("instr_pc", idx, instr_pc_o, t.e_ipc);
            chk("instr", idx, instr_o, t.e_ins);
        end
        chk("fetch_pc", idx, fetch_pc_o, t.e_fpc);
        @(posedge clk);
        #1;
    endtask

    vec_t tab[21];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst rd rpc  rrdy rsp rdat          irdy  erv era          eiv eipc         eins          efpc
        // free-run from reset
        tab[0]  = v(1, 0, 0, 0, 0, 0,             0,  0, 0,            0, 0,            0,            32'h0);
        tab[1]  = v(0, 0, 0, 1, 0, 0,             1,  1, 32'h0,        0, 0,            0,            32'h0);
        tab[2]  = v(0, 0, 0, 1, 1, 32'hC000_0000, 1,  0, 0,            0, 0,            0,            32'h4);
        tab[3]  = v(0, 0, 0, 1, 0, 0,             1,  1, 32'h4,        1, 32'h0,        32'hC000_0000, 32'h4);
        tab[4]  = v(0, 0, 0, 1, 1, 32'hC000_0004, 1,  0, 0,            0, 0,            0,            32'h8);
        tab[5]  = v(0, 0, 0, 1, 0, 0,             1,  1, 32'h8,        1, 32'h4,        32'hC000_0004, 32'h8);
        tab[6]  = v(0, 0, 0, 1, 1, 32'hC000_0008, 1,  0, 0,            0, 0,            0,            32'hC);
        tab[7]  = v(0, 0, 0, 1, 0, 0,             1,  1, 32'hC,        1, 32'h8,        32'hC000_0008, 32'hC);
        // reset while WAIT, late response lands in REQ and is ignored
        tab[8]  = v(1, 0, 0, 1, 0, 0,             1,  0, 0,            0, 0,            0,            32'h10);
        tab[9]  = v(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1,  1, 32'h0,        0, 0,            0,            32'h0);
        tab[10] = v(0, 0, 0, 0, 0, 0,             1,  1, 32'h0,        0, 0,            0,            32'h0);
        // decode stalled: two entries buffered, fetch halts at 0x8
        tab[11] = v(0, 0, 0, 1, 0, 0,             0,  1, 32'h0,        0, 0,            0,            32'h0);
        tab[12] = v(0, 0, 0, 1, 1, 32'hC000_0000, 0,  0, 0,            0, 0,            0,            32'h4);
        tab[13] = v(0, 0, 0, 1, 0, 0,             0,  1, 32'h4,        1, 32'h0,        32'hC000_0000, 32'h4);
        tab[14] = v(0, 0, 0, 1, 1, 32'hC000_0004, 0,  0, 0,            1, 32'h0,        32'hC000_0000, 32'h8);
        tab[15] = v(0, 0, 0, 1, 0, 0,             0,  0, 0,            1, 32'h0,        32'hC000_0000, 32'h8);
        tab[16] = v(0, 0, 0, 1, 0, 0,             0,  0, 0,            1, 32'h0,        32'hC000_0000, 32'h8);
        tab[17] = v(0, 0, 0, 1, 0, 0,             1,  0, 0,            1, 32'h0,        32'hC000_0000, 32'h8);
        tab[18] = v(0, 0, 0, 1, 0, 0,             1,  1, 32'h8,        1, 32'h4,        32'hC000_0004, 32'h8);
        tab[19] = v(0, 0, 0, 1, 1, 32'hC000_0008, 1,  0, 0,            0, 0,            0,            32'hC);
        tab[20] = v(0, 0, 0, 1, 0, 0,             1,  1, 32'hC,        1, 32'h8,        32'hC000_0008, 32'hC);

        rst = 1'b1; redirect_valid_i = 1'b0; redirect_pc_i = '0;
        imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0; instr_ready_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        for (int i = 0; i < 21; i++)
            apply(tab[i], i);

        // redirect while WAIT with 0x4 outstanding: response dropped, fetch resumes at 0x100
        apply(v(1, 0, 0,            1, 0, 0,             1, 0, 0,             0, 0,             0,             32'h10),  100);
        apply(v(0, 0, 0,            1, 0, 0,             1, 1, 32'h0,         0, 0,             0,             32'h0),   101);
        apply(v(0, 0, 0,            1, 1, 32'hC000_0000, 1, 0, 0,             0, 0,             0,             32'h4),   102);
        apply(v(0, 0, 0,            1, 0, 0,             1, 1, 32'h4,         1, 32'h0,         32'hC000_0000, 32'h4),   103);
        apply(v(0, 1, 32'h100,      1, 0, 0,             1, 0, 0,             0, 0,             0,             32'h8),   104);
        apply(v(0, 0, 0,            1, 1, 32'hC000_0004, 1, 0, 0,             0, 0,             0,             32'h100), 105);
        apply(v(0, 0, 0,            1, 0, 0,             1, 1, 32'h100,       0, 0,             0,             32'h100), 106);
        apply(v(0, 0, 0,            1, 1, 32'hC000_0100, 1, 0, 0,             0, 0,             0,             32'h104), 107);
        apply(v(0, 0, 0,            1, 0, 0,             1, 1, 32'h104,       1, 32'h100,       32'hC000_0100, 32'h104), 108);

        // redirect coincident with response and a pop: flush wins, data 0x108 never appears
        apply(v(0, 0, 0,            1, 1, 32'hC000_0104, 0, 0, 0,             0, 0,             0,             32'h108), 109);
        apply(v(0, 0, 0,            1, 0, 0,             0, 1, 32'h108,       1, 32'h104,       32'hC000_0104, 32'h108), 110);
        apply(v(0, 1, 32'h200,      1, 1, 32'hC000_0108, 1, 0, 0,             1, 32'h104,       32'hC000_0104, 32'h10C), 111);
        apply(v(0, 0, 0,            1, 0, 0,             1, 1, 32'h200,       0, 0,             0,             32'h200), 112);
        apply(v(0, 0, 0,            1, 1, 32'hC000_0200, 1, 0, 0,             0, 0,             0,             32'h204), 113);
        apply(v(0, 0, 0,            1, 0, 0,             1, 1, 32'h204,       1, 32'h200,       32'hC000_0200, 32'h204), 114);

        // misaligned redirect coincident with a handshake: goes to DROP, target 0x200
        apply(v(0, 0, 0,            1, 1, 32'hC000_0204, 1, 0, 0,             0, 0,             0,             32'h208), 115);
        apply(v(0, 1, 32'h203,      1, 0, 0,             1, 1, 32'h208,       1, 32'h204,       32'hC000_0204, 32'h208), 116);
        apply(v(0, 0, 0,            1, 1, 32'hC000_0208, 1, 0, 0,             0, 0,             0,             32'h200), 117);
        apply(v(0, 0, 0,            0, 0, 0,             1, 1, 32'h200,       0, 0,             0,             32'h200), 118);

        // redirect to top of address space without a handshake, then PC wraps to 0
        apply(v(0, 1, 32'hFFFF_FFFC, 0, 0, 0,            1, 1, 32'h200,       0, 0,             0,             32'h200), 119);
        apply(v(0, 0, 0,            1, 0, 0,             1, 1, 32'hFFFF_FFFC, 0, 0,             0,             32'hFFFF_FFFC), 120);
        apply(v(0, 0, 0,            1, 1, 32'h1234_5678, 1, 0, 0,             0, 0,             0,             32'h0),   121);
        apply(v(0, 0, 0,            0, 0, 0,             1, 1, 32'h0,         1, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0),   122);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage that sits directly downstream of the program counter register. It owns the fetch PC and issues word requests to instruction memory over a valid/ready handshake. It keeps at most one request outstanding and buffers returned instructions, tagged with their PC, in a small FIFO for decode. A redirect input from execute (branch or jump) reloads the PC, flushes the buffer, and discards any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC value loaded by reset.
FIFO_DEPTH, 2, instruction buffer entries; must be a power of two and at least 2.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
redirect_valid_i  input  1  load redirect_pc_i into the fetch PC and flush
redirect_pc_i  input  32  redirect target; bits [1:0] are forced to 0
imem_req_valid_o  output  1  fetch request valid
imem_req_addr_o  output  32  fetch address (word aligned)
imem_req_ready_i  input  1  memory accepts the request
imem_rsp_valid_i  input  1  response data valid (at least 1 cycle after acceptance)
imem_rsp_data_i  input  32  instruction word
instr_valid_o  output  1  buffer head valid
instr_o  output  32  buffer head instruction
instr_pc_o  output  32  PC of the buffer head instruction
instr_ready_i  input  1  decode consumes the head this cycle
fetch_pc_o  output  32  next PC to be requested

Behaviour:
- All state is updated on the rising edge of clk. Reset is synchronous and active-high: with rst high at an edge, fetch_pc becomes RESET_PC, the state becomes REQ, the FIFO is emptied, and the cycle counter is not applicable.
- Output values after reset: imem_req_valid_o=0 during any cycle with rst high; instr_valid_o=0; instr_o=0; instr_pc_o=0; fetch_pc_o=RESET_PC.
- States: REQ, WAIT, DROP. A register req_pc holds the address of the outstanding request.
- REQ:
  - imem_req_valid_o = (count < FIFO_DEPTH) and not rst; imem_req_addr_o = fetch_pc.
  - On a handshake (valid & ready): req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (wraps modulo 2^32), go to WAIT.
  - A response arriving in REQ is ignored.
- WAIT:
  - imem_req_valid_o = 0.
  - On imem_rsp_valid_i: push {req_pc, imem_rsp_data_i} into the FIFO, go to REQ.
  - A push always fits, because a request is issued only when count < FIFO_DEPTH and count cannot grow while in WAIT.
- DROP:
  - imem_req_valid_o = 0.
  - On imem_rsp_valid_i: discard the data, go to REQ.
- Redirect (redirect_valid_i=1, rst=0) takes priority over everything except reset:
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
  - FIFO flushed (count <= 0), so instr_valid_o=0 the next cycle.
  - A pop in the same cycle is overridden by the flush.
  - Next state:
    - REQ with a handshake in the same cycle -> DROP.
    - REQ without a handshake -> REQ. The address changes next cycle; the memory must tolerate a withdrawn request.
    - WAIT with a response in the same cycle -> REQ, and the response is discarded.
    - WAIT without a response -> DROP.
    - DROP -> DROP, with the PC still updated.
- FIFO:
  - instr_valid_o = count != 0; instr_o and instr_pc_o are driven from the head entry.
  - Pop on instr_valid_o & instr_ready_i. Push and pop in the same cycle leave count unchanged.
  - Circular read/write pointers of log2(FIFO_DEPTH) bits wrap naturally.
- Latency: a response in cycle N produces instr_valid_o in cycle N+1. With a 1-cycle memory and a non-stalled decode, throughput is 1 instruction per 2 cycles.
- When full: no request is issued until a pop occurs, and fetch_pc holds.
- Reset during WAIT or DROP: go to REQ. Any late response is ignored because REQ ignores responses.

Test Plan:
- Reset then free-run, with ready=1 always and response 1 cycle after acceptance: requests go to 0x0, 0x4, 0x8; instr_pc_o sequence 0x0, 0x4, 0x8 with matching data; first instr_valid_o 3 cycles after rst deasserts.
- Backpressure, with instr_ready_i=0 and FIFO_DEPTH=2: exactly 2 entries are buffered, imem_req_valid_o=0, fetch_pc_o=0x8 holds. Raising ready drains 0x0 then 0x4 and fetching resumes at 0x8.
- Redirect in WAIT, with the request at 0x4 outstanding, redirect to 0x100: the next response is dropped, the next request address is 0x100, and no instruction with PC 0x4 appears.
- Redirect coincident with the response in WAIT and a pop in the same cycle: FIFO is empty the next cycle, state is REQ, the request goes to the target, and the dropped data never appears.
- Redirect to misaligned 0x203: request address 0x200. Wrap test: redirect to 0xFFFF_FFFC, then the next fetch_pc is 0x0.
- Reset asserted in WAIT, with the late response arriving in the cycle after reset: ignored; the first request is to RESET_PC and the FIFO stays empty.
